tanh_share_arbiter: RTL
=======================

// Module: tanh_share_arbiter
// PURPOSE
//  Shares one tanh_approx datapath among NUM_REQ requesters, e.g. the LSTM gate/cell activation paths.
//  Requesters present operands on valid/ready handshakes. A round-robin arbiter grants one per cycle.
//  The datapath result is registered and returned on a single response channel, tagged with the requester ID.
//  Sits between the recurrent-cell sequencer and the shared activation unit.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  DATA_WIDTH  32  operand/result width, signed fixed point
//  FRAC_WIDTH  16  fractional bits, passed through to tanh_approx
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst        in   1                    synchronous, active-high reset
//  req_valid  in   NUM_REQ              per-requester operand valid
//  req_data   in   NUM_REQ*DATA_WIDTH   packed operands; slice i = requester i
//  req_ready  out  NUM_REQ              one-hot or zero; high only on the granted requester
//  resp_valid out  1                    result register holds a valid result
//  resp_id    out  $clog2(NUM_REQ)      requester index of the held result
//  resp_data  out  DATA_WIDTH           tanh_approx(x) of the granted operand
//  resp_ready in   1                    consumer accepts the result
// BEHAVIOUR
//  - Reset (rst=1 at posedge): resp_valid=0, resp_id=0, resp_data=0, rr_ptr=0.
//    req_ready is 0 while rst=1. Any held result is discarded.
//  - can_accept = !resp_valid || resp_ready (result reg empty, or draining this cycle).
//  - Grant (combinational): scan requesters starting at rr_ptr, wrapping mod NUM_REQ.
//    The first i with req_valid[i] is granted when can_accept=1.
//    req_ready[i]=1 only for the granted i. req_ready is all-zero when no request or !can_accept.
//    req_ready never depends on req_valid of other requesters beyond priority order.
//  - Transfer on requester i: req_valid[i] && req_ready[i].
//    At that edge: resp_data <= tanh_approx(req_data[i]), resp_id <= i, resp_valid <= 1, rr_ptr <= (i+1) mod NUM_REQ.
//  - Response consumed (resp_valid && resp_ready) with no new grant: resp_valid <= 0; data/id hold last value.
//  - Simultaneous drain and grant in the same cycle: resp_valid stays 1 and data/id are replaced.
//    Full throughput is one result per cycle; there are no bubbles.
//  - Backpressure: resp_valid && !resp_ready means no grant. resp_data/resp_id are held stable until accepted.
//  - Latency: operand accepted at edge N gives resp_valid=1 with the result after edge N (1 cycle).
//  - rr_ptr advances only on a grant. It never advances on idle cycles or stalls.
//  - Fairness: a continuously asserted req_valid[i] is granted within NUM_REQ accepted transfers.
//  - Requester rules: req_data[i] must be stable while req_valid[i]=1 and !req_ready[i].
//    A requester must not drop req_valid before its transfer. The block does not check this.
//  - Arithmetic: no modification of operand or result. Width and sign follow DATA_WIDTH/FRAC_WIDTH.
//    The saturation behaviour is the datapath's own.
//  - Reset mid-operation: a pending or held result is lost, and no resp_valid pulse appears after reset.
//    Requesters must re-present their operands.
// STRUCTURE
//  - Shared package act_pkg:
//    - ACT_DATA_WIDTH=32, ACT_FRAC_WIDTH=16
//    - ACT_ONE = 32'sd65536 (1.0 in Q16.16)
//    - ACT_SAT_THRESH = 32'sd4096
//    - typedef act_word_t (signed [ACT_DATA_WIDTH-1:0])
//  - One sub-module: rr_arbiter (NUM_REQ). Inputs req vector, rr_ptr, enable. Outputs one-hot grant and encoded index.
//  - The top instantiates rr_arbiter, one tanh_approx, an operand mux, and the result/ID/valid registers.
// TESTING (NUM_REQ=4, Q16.16)
//  1. Reset: rst high 3 cycles with all req_valid=1.
//     -> req_ready=0, resp_valid=0, resp_id=0, resp_data=0 throughout.
//  2. Single request: req 2 sends x=0x0000_0800.
//     -> req_ready[2] that cycle; next cycle resp_valid=1, resp_id=2, resp_data=0x0000_0800.
//  3. Saturation: req 0 sends x=0x0000_2000.
//     -> resp_data=0x0001_0000; x=0x0000_1000 -> 0x0001_0000.
//  4. All four requesters valid continuously, resp_ready=1.
//     -> grants in order 0,1,2,3,0,...; one resp per cycle; resp_id sequence matches.
//  5. Backpressure: resp_ready=0 for 5 cycles with req 1 and 3 pending.
//     -> resp_data/resp_id stable, req_ready=0; on resp_ready=1, next grant goes to req after rr_ptr.
//  6. Assert rst while resp_valid=1 and resp_ready=0.
//     -> resp_valid=0 next cycle; the first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/act_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : act_pkg
//  Description : Shared constants and types for the activation datapaths.
//                Fixed point is signed Q16.16 by default.
//  Revision    : 1.0 - initial release
// ============================================================================
package act_pkg;

    localparam int ACT_DATA_WIDTH = 32;
    localparam int ACT_FRAC_WIDTH = 16;

    // 1.0 in Q16.16
    localparam logic signed [31:0] ACT_ONE        = 32'sd65536;

    // Magnitude at and above which tanh_approx clamps to +/-ACT_ONE (Q16.16)
    localparam logic signed [31:0] ACT_SAT_THRESH = 32'sd4096;

    typedef logic signed [ACT_DATA_WIDTH-1:0] act_word_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Scans requests starting at
//                i_ptr, wrapping mod NUM_REQ; first hit wins when enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    localparam logic [IDX_W:0] c_NUM = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_sel;

    // Priority scan from the pointer; the earliest position in wrap order wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_sel   = '0;
        if (i_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
                if (w_sum >= c_NUM) begin
                    w_sum = w_sum - c_NUM;
                end
                w_sel = w_sum[IDX_W-1:0];
                if (!o_valid && i_req[w_sel]) begin
                    o_valid = 1'b1;
                    o_idx   = w_sel;
                end
            end
        end
        if (o_valid) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tanh_approx.sv
`default_nettype none
// ============================================================================
//  Module      : tanh_approx
//  Description : Piecewise tanh: identity inside the saturation threshold,
//                clamped to +/-1.0 at or beyond it. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module tanh_approx
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int FRAC_WIDTH = ACT_FRAC_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] i_x,
    output logic signed [DATA_WIDTH-1:0] o_y
);

    // Constants rescaled from the Q16.16 package values to this FRAC_WIDTH
    localparam longint c_ONE_L = longint'(1) << FRAC_WIDTH;
    localparam longint c_THR_L = (longint'(ACT_SAT_THRESH) << FRAC_WIDTH) >>> ACT_FRAC_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] c_ONE     = DATA_WIDTH'(c_ONE_L);
    localparam logic signed [DATA_WIDTH-1:0] c_NEG_ONE = DATA_WIDTH'(-c_ONE_L);
    localparam logic signed [DATA_WIDTH-1:0] c_THR     = DATA_WIDTH'(c_THR_L);
    localparam logic signed [DATA_WIDTH-1:0] c_NEG_THR = DATA_WIDTH'(-c_THR_L);

    // Clamp at the threshold (inclusive), pass through otherwise
    always_comb begin
        if (i_x >= c_THR) begin
            o_y = c_ONE;
        end else if (i_x <= c_NEG_THR) begin
            o_y = c_NEG_ONE;
        end else begin
            o_y = i_x;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tanh_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tanh_share_arbiter
//  Description : Shares one tanh_approx among NUM_REQ requesters. Round-robin
//                grant, one-cycle registered result tagged with requester ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module tanh_share_arbiter
    import act_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int FRAC_WIDTH = ACT_FRAC_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [DATA_WIDTH-1:0]         resp_data,
    input  logic                          resp_ready
);

    localparam int                c_ID_W = $clog2(NUM_REQ);
    localparam logic [c_ID_W-1:0] c_LAST = c_ID_W'(NUM_REQ - 1);

    logic                         r_resp_valid;
    logic [c_ID_W-1:0]            r_resp_id;
    logic signed [DATA_WIDTH-1:0] r_resp_data;
    logic [c_ID_W-1:0]            r_rr_ptr;

    logic                         w_can_accept;
    logic                         w_arb_en;
    logic [NUM_REQ-1:0]           w_grant;
    logic [c_ID_W-1:0]            w_idx;
    logic                         w_arb_valid;
    logic                         w_fire;
    logic signed [DATA_WIDTH-1:0] w_slice [NUM_REQ];
    logic signed [DATA_WIDTH-1:0] w_operand;
    logic signed [DATA_WIDTH-1:0] w_result;

    // Result register is free when empty or being drained this cycle
    assign w_can_accept = !r_resp_valid || resp_ready;
    assign w_arb_en     = w_can_accept && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .i_en    (w_arb_en),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_arb_valid)
    );

    // Grant only ever lands on a valid requester, so a grant is a transfer
    assign req_ready = w_grant;
    assign w_fire    = w_arb_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Operand mux driven by the arbiter's encoded index
    always_comb begin
        w_operand = w_slice[w_idx];
    end

    tanh_approx #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_tanh_approx (
        .i_x (w_operand),
        .o_y (w_result)
    );

    // Result/ID/valid registers and round-robin pointer; pointer moves only on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_rr_ptr     <= '0;
        end else if (w_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_idx;
            r_resp_data  <= w_result;
            r_rr_ptr     <= (w_idx == c_LAST) ? '0 : w_idx + c_ID_W'(1);
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;

endmodule
`default_nettype wire
